// File: rtl/pattern_detector_pkg.sv
// -----------------------------------------------------------------------------
// pattern_detector_pkg
//   Shared constants and helpers for the serial pattern detector.
//   - DEF_PAT_W / DEF_CNT_W : default pattern length and match-counter width
//   - fill_w()              : width needed for a 0..pat_w fill counter
//   - sat_inc()             : saturating increment of a w-bit value
// -----------------------------------------------------------------------------
package pattern_detector_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    // The fill counter has to represent every value from 0 up to pat_w.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Increment v, holding at the all-ones value of a w-bit field.
    // Operates on 32 bits so one helper covers every counter width up to 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/pattern_detector_bit_history.sv
// -----------------------------------------------------------------------------
// bit_history
//   Shift register of the last PAT_W accepted bits plus a fill counter that
//   records how many of those bits are valid (saturates at PAT_W).
//   Ports:
//     clock, reset_n : clock and asynchronous active-low reset
//     accept         : shift `in` into the history this edge
//     clear          : empty the history (wins over accept)
//     in             : serial data bit
//     nxt            : history as it would look after shifting `in` in
//     fill           : number of valid bits currently held (0..PAT_W)
// -----------------------------------------------------------------------------
module bit_history
    import pattern_detector_pkg::*;
#(
    parameter int PAT_W  = DEF_PAT_W,
    parameter int FILL_W = fill_w(PAT_W)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              accept,
    input  logic              clear,
    input  logic              in,
    output logic [PAT_W-1:0]  nxt,
    output logic [FILL_W-1:0] fill
);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Newest bit enters at the LSB; the oldest falls off the MSB.
    assign nxt  = {hist_q[PAT_W-2:0], in};
    assign fill = fill_q;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = nxt;
            fill_d = (fill_q == FILL_W'(PAT_W)) ? fill_q : (fill_q + 1'b1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// -----------------------------------------------------------------------------
// pattern_detector
//   Serial bit-pattern detector with a runtime-loadable pattern, selectable
//   overlap mode and a saturating match counter. Every completed occurrence of
//   the pattern in the accepted bit stream raises `out` for one cycle.
//   Ports:
//     clock, reset_n : clock and asynchronous active-low reset
//     in             : serial data bit
//     x              : sample enable; `in` is taken only on edges with x=1
//     overlap        : 1 keeps history after a match, 0 restarts from empty
//     pat_load       : capture `pattern` and empty the history (beats a sample)
//     pattern        : new pattern, oldest bit in the MSB
//     count_clr      : synchronous clear of match_count (a same-edge hit -> 1)
//     out            : registered one-cycle match pulse
//     match_count    : saturating number of matches
//     armed          : history holds PAT_W valid bits
// -----------------------------------------------------------------------------
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int               PAT_W       = DEF_PAT_W,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011,
    parameter int               CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in,
    input  logic             x,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             count_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int FILL_W = fill_w(PAT_W);

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              out_q, out_d;
    logic [CNT_W-1:0]  match_count_q, match_count_d;

    logic              accept;
    logic              hist_clear;
    logic              hit;
    logic [PAT_W-1:0]  nxt;
    logic [FILL_W-1:0] fill;

    // A load on the same edge discards the sample.
    assign accept = x && !pat_load;

    // The fill gate keeps the reset/cleared zeros in the history from ever
    // completing a match: PAT_W real samples are always required.
    assign hit = accept && (nxt == pat_q) && (fill >= FILL_W'(PAT_W - 1));

    // Non-overlapping mode throws the history away at the edge of the hit.
    assign hist_clear = pat_load || (hit && !overlap);

    bit_history #(
        .PAT_W  (PAT_W),
        .FILL_W (FILL_W)
    ) u_hist (
        .clock   (clock),
        .reset_n (reset_n),
        .accept  (accept),
        .clear   (hist_clear),
        .in      (in),
        .nxt     (nxt),
        .fill    (fill)
    );

    always_comb begin
        pat_d         = pat_q;
        out_d         = hit;
        match_count_d = match_count_q;
        if (pat_load) begin
            pat_d = pattern;
        end
        // A hit on the clearing edge still counts, so the count restarts at 1.
        if (count_clr) begin
            match_count_d = hit ? CNT_W'(1) : '0;
        end else if (hit) begin
            match_count_d = CNT_W'(sat_inc(32'(match_count_q), CNT_W));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q         <= DEFAULT_PAT;
            out_q         <= 1'b0;
            match_count_q <= '0;
        end else begin
            pat_q         <= pat_d;
            out_q         <= out_d;
            match_count_q <= match_count_d;
        end
    end

    assign out         = out_q;
    assign match_count = match_count_q;
    assign armed       = (fill == FILL_W'(PAT_W));

endmodule

// File: tb/tb_pattern_detector.sv
module tb_pattern_detector;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------------------------------------------------------- clock/reset
    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in = 1'b0;
    logic             x = 1'b0;
    logic             overlap = 1'b0;
    logic             pat_load = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic             count_clr = 1'b0;
    logic             out;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    always #5 clock = ~clock;

    pattern_detector #(
        .PAT_W       (PAT_W),
        .DEFAULT_PAT (4'b1011),
        .CNT_W       (CNT_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in          (in),
        .x           (x),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pattern     (pattern),
        .count_clr   (count_clr),
        .out         (out),
        .match_count (match_count),
        .armed       (armed)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the list of accepted bits since the last clear, oldest
    // first. A match is the last PAT_W of them read as a number equal to the
    // pattern; only the last PAT_W bits ever matter so older ones are dropped.
    logic             m_bits[$];
    logic [PAT_W-1:0] m_pat = 4'b1011;
    int               m_cnt = 0;
    logic             m_out = 1'b0;

    task automatic model_reset();
        m_bits.delete();
        m_pat = 4'b1011;
        m_cnt = 0;
        m_out = 1'b0;
    endtask

    task automatic model_edge(input logic b, input logic xv, input logic ov,
                              input logic ld, input logic [PAT_W-1:0] pv,
                              input logic clr);
        logic             hit;
        logic [PAT_W-1:0] v;
        hit = 1'b0;
        if (ld) begin
            m_pat = pv;
            m_bits.delete();
        end else if (xv) begin
            m_bits.push_back(b);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            if (m_bits.size() == PAT_W) begin
                v = '0;
                foreach (m_bits[i]) v = {v[PAT_W-2:0], m_bits[i]};
                hit = (v == m_pat);
            end
            if (hit && !ov) m_bits.delete();
        end
        m_out = hit;
        if (clr) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_out"},   32'(out),         32'(m_out));
        check({tag, "_count"}, 32'(match_count), 32'(m_cnt));
        check({tag, "_armed"}, 32'(armed),       32'(m_bits.size() == PAT_W));
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic step(input string tag, input logic b, input logic xv, input logic ov,
                        input logic ld, input logic [PAT_W-1:0] pv, input logic clr);
        @(negedge clock);
        in        = b;
        x         = xv;
        overlap   = ov;
        pat_load  = ld;
        pattern   = pv;
        count_clr = clr;
        @(posedge clock);
        model_edge(b, xv, ov, ld, pv, clr);
        #1;
        compare_all(tag);
    endtask

    task automatic sample(input string tag, input logic b, input logic ov);
        step(tag, b, 1'b1, ov, 1'b0, '0, 1'b0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic load(input string tag, input logic [PAT_W-1:0] pv);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, pv, 1'b0);
    endtask

    task automatic clear_count(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic stream(input string tag, input logic [15:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) sample(tag, bits[i], ov);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clock);
        x = 1'b0;
        pat_load = 1'b0;
        count_clr = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Reset state
        #1;
        compare_all("reset");
        #12;
        @(negedge clock);
        reset_n = 1'b1;

        // Default pattern 1011, overlapping: hits after samples 4 and 7
        stream("ovl", 16'b1011011, 7, 1'b1);
        check("ovl_total", 32'(match_count), 32'd2);

        // Same stream without overlap: single hit
        clear_count("clr1");
        load("reload", 4'b1011);
        stream("novl", 16'b1011011, 7, 1'b0);
        check("novl_total", 32'(match_count), 32'd1);

        // All-zero pattern needs PAT_W real zeros
        load("zero_ld", 4'b0000);
        stream("zero_pre", 16'b000, 3, 1'b1);
        check("zero_pre_out", 32'(out), 32'd0);
        check("zero_pre_armed", 32'(armed), 32'd0);
        sample("zero_hit", 1'b0, 1'b1);
        check("zero_hit_out", 32'(out), 32'd1);
        check("zero_hit_armed", 32'(armed), 32'd1);

        // Gaps in x do not break a partial match
        load("gap_ld", 4'b1011);
        stream("gap_pre", 16'b101, 3, 1'b1);
        idle("gap_idle", 5);
        sample("gap_hit", 1'b1, 1'b1);
        check("gap_hit_out", 32'(out), 32'd1);
        idle("gap_after", 1);
        check("gap_pulse_1cyc", 32'(out), 32'd0);

        // Load beats a completing sample; the new pattern is then active
        stream("ldp_pre", 16'b101, 3, 1'b1);
        step("ldp", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        check("ldp_out", 32'(out), 32'd0);
        check("ldp_armed", 32'(armed), 32'd0);
        stream("ldp_new", 16'b0110, 4, 1'b0);
        check("ldp_new_out", 32'(out), 32'd1);

        // Saturation, then count_clr together with a hit
        load("sat_ld", 4'b1111);
        for (int i = 0; i < 300; i++) sample("sat", 1'b1, 1'b1);
        check("sat_total", 32'(match_count), 32'(CNT_MAX));
        step("clr_hit", 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        check("clr_hit_count", 32'(match_count), 32'd1);

        // Asynchronous reset mid-pattern
        load("rst_ld", 4'b1011);
        stream("rst_pre", 16'b101, 3, 1'b1);
        async_reset("rst_mid");
        sample("rst_one", 1'b1, 1'b1);
        check("rst_one_out", 32'(out), 32'd0);
        stream("rst_full", 16'b1011, 4, 1'b1);
        check("rst_full_out", 32'(out), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic             b, xv, ov, ld, clr;
            logic [PAT_W-1:0] pv;
            b   = 1'($urandom_range(0, 1));
            xv  = ($urandom_range(0, 3) != 0);
            ov  = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 39) == 0);
            pv  = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
            step("rand", b, xv, ov, ld, pv, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
